// File: rtl/tff_seq_pkg.sv
// tff_seq_pkg: shared state encoding and direction constants for the TFF count sequencer.
package tff_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/tff_cell.sv
// tff_cell: single T flip-flop with asynchronous active-low reset and complementary output.
module tff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q,
    output logic qb
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= 1'b0;
        else        q <= q ^ t;
    end

    assign qb = ~q;

endmodule

// File: rtl/tff_count_seq.sv
// tff_count_seq: start/busy/done sequencer driving a toggle-only TFF bank as an up/down counter.
// Define TFF_SEQ_WRAP_EN for periodic mode (wrap at end value, done pulses once per period).
module tff_count_seq
    import tff_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] t_en,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nx;
    logic             dir_r;
    logic [WIDTH-1:0] lim_r, start_val, end_val, up_t, dn_t, qb;
    logic             accept, at_end;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (.clk(clk), .rst_n(rst_n), .t(t_en[i]), .q(q[i]), .qb(qb[i]));
    end

    // Bit i toggles when all lower bits are 1 (up) or all 0 (down).
    assign up_t[0] = 1'b1;
    assign dn_t[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_tog
        assign up_t[i] = &q[i-1:0];
        assign dn_t[i] = &qb[i-1:0];
    end

    assign start_val = (dir_r == DIR_UP) ? '0 : lim_r;
    assign end_val   = (dir_r == DIR_UP) ? lim_r : '0;
    assign at_end    = (q == end_val);
    assign accept    = start && (state == ST_IDLE || state == ST_DONE);
    assign busy      = (state == ST_CLEAR) || (state == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            dir_r <= DIR_DN;
            lim_r <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                dir_r <= dir;
                lim_r <= limit;
            end
        end
    end

    always_comb begin
        state_nx = state;
        t_en     = '0;
        case (state)
            ST_IDLE:  state_nx = start ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: begin
                t_en     = q ^ start_val;
                state_nx = stop ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (stop) state_nx = ST_IDLE;
                else if (at_end) begin
`ifdef TFF_SEQ_WRAP_EN
                    t_en = q ^ start_val;
`else
                    state_nx = ST_DONE;
`endif
                end else t_en = (dir_r == DIR_UP) ? up_t : dn_t;
            end
            ST_DONE:  state_nx = start ? ST_CLEAR : ST_DONE;
            default:  state_nx = ST_IDLE;
        endcase
    end

`ifdef TFF_SEQ_WRAP_EN
    assign done = (state == ST_RUN) && !stop && at_end;
`else
    assign done = (state == ST_DONE);
`endif

endmodule

// File: tb/tb_tff_count_seq.sv
// tb_tff_count_seq: directed scoreboard bench for tff_count_seq (WIDTH=4); TFF_SEQ_WRAP_EN selects the periodic sequence.
module tb_tff_count_seq;

    logic       clk, rst_n, start, stop, dir, busy, done;
    logic [3:0] limit, t_en, q;

    typedef struct {
        string      tag;
        logic [3:0] q;
        logic       busy;
        logic       done;
        logic [3:0] t_en;
    } exp_t;

    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fail    = 0;

    tff_count_seq #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir),
        .limit(limit), .t_en(t_en), .q(q), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] eq, input logic eb, input logic ed,
                        input logic [3:0] et);
        exp_t e;
        e.tag = tag; e.q = eq; e.busy = eb; e.done = ed; e.t_en = et;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp({e.tag, ".q"}, q, e.q);
            cmp({e.tag, ".busy"}, {3'b0, busy}, {3'b0, e.busy});
            cmp({e.tag, ".done"}, {3'b0, done}, {3'b0, e.done});
            cmp({e.tag, ".t_en"}, t_en, e.t_en);
        end
    endtask

    // Drive inputs for the coming edge, check outputs in the current state, then advance one edge.
    task automatic step(input logic s, input logic p, input logic d, input logic [3:0] l,
                        input string tag, input logic [3:0] eq, input logic eb, input logic ed,
                        input logic [3:0] et);
        start = s; stop = p; dir = d; limit = l;
        push(tag, eq, eb, ed, et);
        #1;
        check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0; limit = 4'd0;
        #12;
        push("reset", 4'd0, 1'b0, 1'b0, 4'd0);
        check();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
`ifndef TFF_SEQ_WRAP_EN
        // Count up 0..9, done 11 edges after start.
        step(1, 0, 1, 4'd9, "up9.idle", 4'd0, 0, 0, 4'd0);
        step(0, 0, 1, 4'd9, "up9.clear", 4'd0, 1, 0, 4'd0);
        for (int i = 0; i < 9; i++)
            step(0, 0, 1, 4'd9, $sformatf("up9.run%0d", i), 4'(i), 1, 0, 4'(i ^ (i + 1)));
        step(0, 0, 1, 4'd9, "up9.end", 4'd9, 1, 0, 4'd0);
        step(0, 0, 1, 4'd9, "up9.done0", 4'd9, 0, 1, 4'd0);
        step(0, 0, 1, 4'd9, "up9.done1", 4'd9, 0, 1, 4'd0);
        // Count down from 12; start/dir/limit wiggled while busy must be ignored.
        step(1, 0, 0, 4'd12, "dn12.restart", 4'd9, 0, 1, 4'd0);
        step(1, 0, 1, 4'd5, "dn12.clear", 4'd9, 1, 0, 4'd9 ^ 4'd12);
        for (int i = 12; i > 0; i--)
            step(1, 0, 1, 4'd5, $sformatf("dn12.run%0d", i), 4'(i), 1, 0, 4'(i ^ (i - 1)));
        step(0, 0, 0, 4'd12, "dn12.end", 4'd0, 1, 0, 4'd0);
        step(0, 0, 0, 4'd12, "dn12.done", 4'd0, 0, 1, 4'd0);
        // Stop at 6 freezes the count; next start clears it in one cycle.
        step(1, 0, 1, 4'd15, "stop.restart", 4'd0, 0, 1, 4'd0);
        step(0, 0, 1, 4'd15, "stop.clear", 4'd0, 1, 0, 4'd0);
        for (int i = 0; i < 6; i++)
            step(0, 0, 1, 4'd15, $sformatf("stop.run%0d", i), 4'(i), 1, 0, 4'(i ^ (i + 1)));
        step(0, 1, 1, 4'd15, "stop.at6", 4'd6, 1, 0, 4'd0);
        step(0, 1, 1, 4'd15, "stop.idle0", 4'd6, 0, 0, 4'd0);
        step(1, 0, 1, 4'd15, "stop.idle1", 4'd6, 0, 0, 4'd0);
        step(0, 0, 1, 4'd15, "stop.clr6", 4'd6, 1, 0, 4'b0110);
        step(0, 1, 1, 4'd15, "stop.run0", 4'd0, 1, 0, 4'd0);
        // Stop during CLEAR still applies the preset.
        step(1, 0, 0, 4'd10, "clrstop.idle", 4'd0, 0, 0, 4'd0);
        step(0, 1, 0, 4'd10, "clrstop.clear", 4'd0, 1, 0, 4'd10);
        step(0, 0, 0, 4'd10, "clrstop.idle2", 4'd10, 0, 0, 4'd0);
        // limit = 0 in both directions.
        step(1, 0, 1, 4'd0, "lim0up.idle", 4'd10, 0, 0, 4'd0);
        step(0, 0, 1, 4'd0, "lim0up.clear", 4'd10, 1, 0, 4'd10);
        step(0, 0, 1, 4'd0, "lim0up.run", 4'd0, 1, 0, 4'd0);
        step(1, 0, 0, 4'd0, "lim0dn.restart", 4'd0, 0, 1, 4'd0);
        step(0, 0, 0, 4'd0, "lim0dn.clear", 4'd0, 1, 0, 4'd0);
        step(0, 0, 0, 4'd0, "lim0dn.run", 4'd0, 1, 0, 4'd0);
        // Restart from DONE; limit/dir changes while busy do not matter.
        step(1, 0, 1, 4'd2, "chg.restart", 4'd0, 0, 1, 4'd0);
        step(0, 0, 0, 4'd7, "chg.clear", 4'd0, 1, 0, 4'd0);
        step(0, 0, 0, 4'd7, "chg.run0", 4'd0, 1, 0, 4'd1);
        step(0, 0, 0, 4'd7, "chg.run1", 4'd1, 1, 0, 4'd3);
        step(0, 0, 0, 4'd7, "chg.run2", 4'd2, 1, 0, 4'd0);
        step(0, 0, 0, 4'd7, "chg.done", 4'd2, 0, 1, 4'd0);
        // Async reset mid-RUN at q=5 takes effect before the next edge.
        step(1, 0, 1, 4'd9, "rst.restart", 4'd2, 0, 1, 4'd0);
        step(0, 0, 1, 4'd9, "rst.clear", 4'd2, 1, 0, 4'd2);
        for (int i = 0; i < 5; i++)
            step(0, 0, 1, 4'd9, $sformatf("rst.run%0d", i), 4'(i), 1, 0, 4'(i ^ (i + 1)));
        push("rst.pre", 4'd5, 1'b1, 1'b0, 4'd5 ^ 4'd6);
        check();
        #1 rst_n = 1'b0;
        #1;
        push("rst.async", 4'd0, 1'b0, 1'b0, 4'd0);
        check();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, 0, 1, 4'd9, "rst.idle", 4'd0, 0, 0, 4'd0);
`else
        // Periodic mode: 0,1,2,3,0,... with a done pulse at each 3.
        step(1, 0, 1, 4'd3, "wrap.idle", 4'd0, 0, 0, 4'd0);
        step(0, 0, 1, 4'd3, "wrap.clear", 4'd0, 1, 0, 4'd0);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 3; i++)
                step(0, 0, 1, 4'd3, $sformatf("wrap.p%0d.q%0d", p, i), 4'(i), 1, 0, 4'(i ^ (i + 1)));
            step(0, 0, 1, 4'd3, $sformatf("wrap.p%0d.q3", p), 4'd3, 1, 1, 4'd3);
        end
        step(0, 0, 1, 4'd3, "wrap.q0", 4'd0, 1, 0, 4'd1);
        step(0, 1, 1, 4'd3, "wrap.stop", 4'd1, 1, 0, 4'd0);
        step(0, 0, 1, 4'd3, "wrap.idle2", 4'd1, 0, 0, 4'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
